// File: rtl/vecram_arbiter_if.sv
// Request/response bundle for the vector RAM arbiter: loader, CPU and AVG ports plus the RAM bus.
// slave = arbiter side; master = requesters together with the RAM.
interface vecram_arbiter_if #(
   parameter int ADDR_W = 13
);
   logic              dl_wr;
   logic [ADDR_W-1:0] dl_addr;
   logic [7:0]        dl_data;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic              cpu_ack;

   logic              avg_req;
   logic [ADDR_W-2:0] avg_addr;
   logic [15:0]       avg_inst;
   logic              avg_valid;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;

   modport slave (
      input  dl_wr, dl_addr, dl_data,
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_ack,
      input  avg_req, avg_addr,
      output avg_inst, avg_valid,
      output ram_addr, ram_we, ram_din,
      input  ram_dout
   );

   modport master (
      output dl_wr, dl_addr, dl_data,
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ack,
      output avg_req, avg_addr,
      input  avg_inst, avg_valid,
      input  ram_addr, ram_we, ram_din,
      output ram_dout
   );
endinterface

// File: rtl/vecram_arbiter.sv
// Single-port vector RAM arbiter: loader > CPU > AVG, AVG promoted after STARVE_LIMIT waiting cycles.
// CPU ack 2 cycles after grant, AVG valid 3 after grant; each loader write on an issue cycle stalls 1 cycle.
module vecram_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int STARVE_LIMIT = 16
) (
   input logic           clk,
   input logic           rst,
   vecram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CPU_WAIT,
      CPU_ACK,
      AVG_ODD,
      AVG_WAIT,
      AVG_ACK
   } state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t            state, state_nxt;
   logic [7:0]        starve;
   logic              hi_pending;
   logic [ADDR_W-2:0] avg_lat;
   logic              cpu_we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        cpu_dout_q;
   logic [15:0]       avg_inst_q;

   logic              grant_cpu, grant_avg;
   logic              issue, issue_we;
   logic [ADDR_W-1:0] issue_addr;
   logic [7:0]        issue_din;
   logic              avg_busy;
   logic [ADDR_W-1:0] ram_addr_c;

   // A loader write suppresses every issue; the FSM then simply holds its state.
   always_comb begin
      state_nxt  = state;
      grant_cpu  = 1'b0;
      grant_avg  = 1'b0;
      issue      = 1'b0;
      issue_we   = 1'b0;
      issue_addr = addr_q;
      issue_din  = 8'h00;
      case (state)
         IDLE: begin
            if (!bus.dl_wr) begin
               if (bus.cpu_req && (!bus.avg_req || starve < LIMIT)) begin
                  grant_cpu  = 1'b1;
                  issue      = 1'b1;
                  issue_we   = bus.cpu_we;
                  issue_addr = bus.cpu_addr;
                  issue_din  = bus.cpu_din;
                  state_nxt  = CPU_WAIT;
               end else if (bus.avg_req) begin
                  grant_avg  = 1'b1;
                  issue      = 1'b1;
                  issue_addr = {bus.avg_addr, 1'b0};
                  state_nxt  = AVG_ODD;
               end
            end
         end
         CPU_WAIT: state_nxt = CPU_ACK;
         CPU_ACK:  state_nxt = IDLE;
         AVG_ODD: begin
            if (!bus.dl_wr) begin
               issue      = 1'b1;
               issue_addr = {avg_lat, 1'b1};
               state_nxt  = AVG_WAIT;
            end
         end
         AVG_WAIT: state_nxt = AVG_ACK;
         AVG_ACK:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign avg_busy   = (state == AVG_ODD) || (state == AVG_WAIT) || (state == AVG_ACK);
   assign ram_addr_c = bus.dl_wr ? bus.dl_addr : issue_addr;

   assign bus.ram_addr  = ram_addr_c;
   assign bus.ram_we    = bus.dl_wr | (issue & issue_we);
   assign bus.ram_din   = bus.dl_wr ? bus.dl_data : issue_din;
   assign bus.cpu_dout  = cpu_dout_q;
   assign bus.cpu_ack   = (state == CPU_ACK);
   assign bus.avg_inst  = avg_inst_q;
   assign bus.avg_valid = (state == AVG_ACK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve     <= 8'h00;
         hi_pending <= 1'b0;
         avg_lat    <= '0;
         cpu_we_q   <= 1'b0;
         addr_q     <= '0;
         cpu_dout_q <= 8'h00;
         avg_inst_q <= 16'h0000;
      end else begin
         state  <= state_nxt;
         addr_q <= ram_addr_c;
         if (grant_cpu)
            cpu_we_q <= bus.cpu_we;
         if (grant_avg) begin
            avg_lat    <= bus.avg_addr;
            hi_pending <= 1'b1;
         end
         if (state == CPU_WAIT && !cpu_we_q)
            cpu_dout_q <= bus.ram_dout;
         // Even byte lands here even if a loader write stalls the odd issue.
         if (state == AVG_ODD && hi_pending) begin
            avg_inst_q[15:8] <= bus.ram_dout;
            hi_pending       <= 1'b0;
         end
         if (state == AVG_WAIT)
            avg_inst_q[7:0] <= bus.ram_dout;
         // Only cycles spent waiting for a grant count as starvation.
         if (grant_avg || !bus.avg_req)
            starve <= 8'h00;
         else if (!avg_busy && starve < LIMIT)
            starve <= starve + 8'h01;
      end
   end

endmodule

// File: tb/tb_vecram_arbiter.sv
// Directed bench for vecram_arbiter with a RAM model and a reference memory image.
module tb_vecram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vecram_arbiter_if #(.ADDR_W(13)) bus();

   vecram_arbiter #(.ADDR_W(13), .STARVE_LIMIT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // RAM model: 1-cycle read latency, read-before-write.
   logic [7:0] mem [0:8191];
   logic [7:0] rd_tmp;
   initial for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
   always @(posedge clk) begin
      rd_tmp = mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
      bus.ram_dout <= rd_tmp;
   end

   // Reference image and transaction context kept by the bench.
   logic [7:0]  ref_mem [0:8191];
   logic        cpu_active = 1'b0;
   logic        avg_active = 1'b0;
   logic        cur_cpu_we = 1'b0;
   logic [12:0] cur_cpu_addr = '0;
   logic [11:0] cur_avg_addr = '0;
   logic [7:0]  model_cpu_dout = 8'h00;
   logic [12:0] ra_trace [0:63];
   logic        rwe_trace [0:63];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of the DUT against the bench's view of the world.
   always @(negedge clk) begin
      if (rst) begin
         model_cpu_dout = 8'h00;
         chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
         chk("rst_avg_valid", 32'(bus.avg_valid), 32'h0);
         chk("rst_cpu_dout",  32'(bus.cpu_dout),  32'h0);
         chk("rst_avg_inst",  32'(bus.avg_inst),  32'h0);
      end else begin
         if (bus.dl_wr) begin
            chk("dl_ram_we",   32'(bus.ram_we),   32'h1);
            chk("dl_ram_addr", 32'(bus.ram_addr), 32'(bus.dl_addr));
            chk("dl_ram_din",  32'(bus.ram_din),  32'(bus.dl_data));
         end else if (!cpu_active) begin
            chk("idle_ram_we", 32'(bus.ram_we), 32'h0);
         end
         if (bus.cpu_ack) begin
            if (!cpu_active)
               chk("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'h0);
            else begin
               if (!cur_cpu_we) model_cpu_dout = ref_mem[cur_cpu_addr];
               chk("cpu_dout", 32'(bus.cpu_dout), 32'(model_cpu_dout));
            end
         end
         if (bus.avg_valid) begin
            if (!avg_active)
               chk("avg_valid_unexpected", 32'(bus.avg_valid), 32'h0);
            else
               chk("avg_inst", 32'(bus.avg_inst),
                   32'({ref_mem[{cur_avg_addr, 1'b0}], ref_mem[{cur_avg_addr, 1'b1}]}));
         end
      end
   end

   task automatic dl_write(input logic [12:0] a, input logic [7:0] d);
      bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      bus.dl_wr = 1'b0;
   endtask

   task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] dout);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
      cur_cpu_we = we; cur_cpu_addr = a; cpu_active = 1'b1;
      if (we) ref_mem[a] = d;
      lat = -1; dout = 8'h00;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         ra_trace[k] = bus.ram_addr; rwe_trace[k] = bus.ram_we;
         if (bus.cpu_ack) begin lat = k; dout = bus.cpu_dout; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; cpu_active = 1'b0;
   endtask

   task automatic avg_fetch(input logic [11:0] wa, input int dl_at, input logic [12:0] dla,
                            input logic [7:0] dld, output int lat, output logic [15:0] inst);
      bus.avg_req = 1'b1; bus.avg_addr = wa; cur_avg_addr = wa; avg_active = 1'b1;
      lat = -1; inst = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         bus.dl_wr = (k == dl_at); bus.dl_addr = dla; bus.dl_data = dld;
         if (k == dl_at) ref_mem[dla] = dld;
         @(negedge clk);
         ra_trace[k] = bus.ram_addr; rwe_trace[k] = bus.ram_we;
         if (bus.avg_valid) begin lat = k; inst = bus.avg_inst; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.avg_req = 1'b0; bus.dl_wr = 1'b0; avg_active = 1'b0;
   endtask

   int          lat;
   logic [7:0]  dout;
   logic [15:0] inst;
   int          grant_k, valid_k, acks_before, ack_k;

   initial begin
      for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
      bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      bus.avg_req = 1'b0; bus.avg_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // CPU read
      dl_write(13'h0123, 8'h5A);
      cpu_op(1'b0, 13'h0123, 8'h00, lat, dout);
      chk("cpu_rd_lat",  32'(lat),         32'd2);
      chk("cpu_rd_data", 32'(dout),        32'h5A);
      chk("cpu_rd_addr", 32'(ra_trace[0]), 32'h0123);

      // AVG fetch
      dl_write(13'h0400, 8'h12);
      dl_write(13'h0401, 8'h34);
      avg_fetch(12'h200, -1, 13'h0000, 8'h00, lat, inst);
      chk("avg_lat",   32'(lat),         32'd3);
      chk("avg_data",  32'(inst),        32'h1234);
      chk("avg_even",  32'(ra_trace[0]), 32'h0400);
      chk("avg_odd",   32'(ra_trace[1]), 32'h0401);

      // Loader collides with the odd-byte issue
      avg_fetch(12'h200, 1, 13'h1000, 8'hAA, lat, inst);
      chk("coll_lat",   32'(lat),         32'd4);
      chk("coll_data",  32'(inst),        32'h1234);
      chk("coll_c1",    32'(ra_trace[1]), 32'h1000);
      chk("coll_odd",   32'(ra_trace[2]), 32'h0401);
      cpu_op(1'b0, 13'h1000, 8'h00, lat, dout);
      chk("coll_mem",   32'(dout),        32'hAA);

      // CPU write then readback
      cpu_op(1'b1, 13'h0005, 8'h77, lat, dout);
      chk("cpu_wr_lat",  32'(lat),          32'd2);
      chk("cpu_wr_we",   32'(rwe_trace[0]), 32'h1);
      chk("cpu_wr_addr", 32'(ra_trace[0]),  32'h0005);
      chk("cpu_wr_dout", 32'(dout),         32'hAA);
      cpu_op(1'b0, 13'h0005, 8'h00, lat, dout);
      chk("cpu_rb_data", 32'(dout),         32'h77);

      // Starvation: CPU re-presents immediately after every ack, AVG waits.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
      cur_cpu_we = 1'b0; cur_cpu_addr = 13'h0123; cpu_active = 1'b1;
      bus.avg_req = 1'b1; bus.avg_addr = 12'h300; cur_avg_addr = 12'h300; avg_active = 1'b1;
      grant_k = -1; valid_k = -1; acks_before = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (grant_k < 0 && !bus.ram_we && bus.ram_addr == 13'h0600) grant_k = k;
         if (grant_k < 0 && bus.cpu_ack) acks_before++;
         if (bus.avg_valid) valid_k = k;
         @(posedge clk); #1;
         if (valid_k >= 0) begin bus.avg_req = 1'b0; avg_active = 1'b0; break; end
      end
      ack_k = -1;
      for (int k = valid_k + 1; k < valid_k + 12; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin ack_k = k; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; cpu_active = 1'b0;
      chk("starve_grant", 32'(grant_k),     32'd18);
      chk("starve_acks",  32'(acks_before), 32'd6);
      chk("starve_valid", 32'(valid_k),     32'd21);
      chk("starve_cpu",   32'(ack_k),       32'd24);

      // Counter cleared: the next contention starts the count from zero again.
      avg_fetch(12'h300, -1, 13'h0000, 8'h00, lat, inst);
      chk("post_starve_lat", 32'(lat), 32'd3);

      // Reset in the middle of an AVG fetch
      bus.avg_req = 1'b1; bus.avg_addr = 12'h200; cur_avg_addr = 12'h200; avg_active = 1'b1;
      @(posedge clk); #1;
      avg_active = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_avg_valid", 32'(bus.avg_valid), 32'h0);
      chk("midrst_avg_inst",  32'(bus.avg_inst),  32'h0);
      chk("midrst_cpu_dout",  32'(bus.cpu_dout),  32'h0);
      @(posedge clk); #1;
      bus.avg_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      avg_fetch(12'h200, -1, 13'h0000, 8'h00, lat, inst);
      chk("after_rst_lat",  32'(lat),  32'd3);
      chk("after_rst_data", 32'(inst), 32'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
